// File: rtl/ahb_sram_subordinate.sv
// rtl/ahb_sram_subordinate.sv - AHB5-Lite subordinate fronting a word-organised register-file SRAM
//
// Purpose: decodes AHB5-Lite address phases, inserts programmable wait states,
//   applies byte strobes limited to the lanes selected by hsize/haddr, and
//   answers illegal transfers with the two-cycle ERROR response.
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   hsel, haddr, htrans   address phase select / address / transfer type
//   hwrite, hsize         direction and log2 transfer size, latched at acceptance
//   hburst, hprot, hexcl  accepted but unused (no exclusive monitor)
//   hwdata, hwstrb        data phase write data and byte strobes
//   hready_i              system-wide HREADY
//   hrdata                read data, valid in the completing data-phase cycle
//   hreadyout, hresp      data phase extend / response
//   hexokay               exclusive okay, always 0
module ahb_sram_subordinate #(
  parameter int             AW          = 32,
  parameter int             DW          = 32,
  parameter int             DEPTH       = 1024,
  parameter logic [AW-1:0]  BASE_ADDR   = '0,
  parameter int             WAIT_STATES = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            hsel,
  input  logic [AW-1:0]   haddr,
  input  logic [1:0]      htrans,
  input  logic            hwrite,
  input  logic [2:0]      hsize,
  input  logic [2:0]      hburst,
  input  logic [6:0]      hprot,
  input  logic            hexcl,
  input  logic [DW-1:0]   hwdata,
  input  logic [DW/8-1:0] hwstrb,
  input  logic            hready_i,
  output logic [DW-1:0]   hrdata,
  output logic            hreadyout,
  output logic            hresp,
  output logic            hexokay
);

  localparam int DS  = DW / 8;
  localparam int LSB = $clog2(DS);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [63:0] BASE64  = 64'(BASE_ADDR);
  localparam logic [63:0] SPAN    = 64'(DEPTH) * 64'(DS);
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2,
    S_DONE
  } state_t;

  localparam state_t GOOD_NEXT = (WAIT_STATES > 0) ? S_WAIT : S_DONE;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [LSB-1:0] lo_q;
  logic [2:0]    size_q;
  logic          wr_q;
  logic [3:0]    cnt_q;

  logic [DW-1:0] mem [DEPTH];

  // Address decode done in 64 bits so BASE_ADDR + span never wraps.
  logic [63:0] addr64, offset64;
  logic        in_range, size_bad, misaligned, bad, take;
  logic [DS-1:0] lane_mask;

  assign addr64     = 64'(haddr);
  assign offset64   = addr64 - BASE64;
  assign in_range   = (addr64 >= BASE64) && (offset64 < SPAN);
  assign size_bad   = {29'd0, hsize} > 32'(LSB);
  assign misaligned = (addr64 & ((64'd1 << hsize) - 64'd1)) != 64'd0;
  assign bad        = !in_range || size_bad || misaligned;

  // New address phases are only taken where the data phase is not being extended.
  assign take = hsel && hready_i && htrans[1] &&
                ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2));

  assign hexokay = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{hburst, hprot, hexcl, htrans[0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lo_q    <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        idx_q  <= offset64[LSB +: IW];
        lo_q   <= haddr[LSB-1:0];
        size_q <= hsize;
        wr_q   <= hwrite;
      end
      if (take && !bad)
        cnt_q <= WS_LOAD;
      else if ((state_q == S_WAIT) && (cnt_q != 4'd0))
        cnt_q <= cnt_q - 4'd1;
    end
  end

  // Bytes covered by the latched transfer; strobes outside this window are ignored.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < DS; i++) begin
      if ((i >= int'(lo_q)) && (i < int'(lo_q) + (1 << size_q)))
        lane_mask[i] = 1'b1;
    end
  end

  // Write commits at the end of the completing cycle, so a pipelined read of
  // the same word entering DONE on the next cycle already sees the new data.
  always_ff @(posedge clk_i) begin
    if ((state_q == S_DONE) && wr_q && hready_i) begin
      for (int i = 0; i < DS; i++) begin
        if (hwstrb[i] && lane_mask[i])
          mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    hrdata    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (take)
          state_d = bad ? S_ERR1 : GOOD_NEXT;
      end
      S_WAIT: begin
        hreadyout = 1'b0;
        if (cnt_q == 4'd0)
          state_d = S_DONE;
      end
      S_DONE: begin
        if (!wr_q)
          hrdata = mem[idx_q];
        if (hready_i)
          state_d = take ? (bad ? S_ERR1 : GOOD_NEXT) : S_IDLE;
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        hresp = 1'b1;
        if (hready_i)
          state_d = take ? (bad ? S_ERR1 : GOOD_NEXT) : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
